// File: rtl/load_store_unit.sv
// Memory-access / write-back stage: RV32I loads and stores over a req/gnt/rvalid bus,
// with regfile write-back and a done/err handshake back to the controller.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        wb_reg,
    input  logic [4:0]  rd_num,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    output logic        wb_enable,
    output logic [4:0]  wb_rd_num,
    output logic [31:0] wb_rd_data,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] LAST_WAIT_COUNT = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_isStore;
    logic [2:0]  r_func3;
    logic        r_wbReg;
    logic [4:0]  r_rdNum;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_result;
    logic        r_err;
    logic [7:0]  r_count;

    logic        w_isLoad;
    logic        w_isStore;
    logic        w_func3Ok;
    logic        w_misaligned;
    logic        w_decodeErr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;
    logic [31:0] w_loadData;
    logic        w_timeoutHit;
    logic        w_wbEn;

    // Decode straight from the inputs so the decision is ready at the capture edge.
    always_comb begin
        w_isLoad     = (opcode == OP_LOAD);
        w_isStore    = (opcode == OP_STORE);
        w_func3Ok    = 1'b0;
        w_misaligned = 1'b0;
        if (w_isLoad) begin
            w_func3Ok = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2) ||
                        (func3 == 3'd4) || (func3 == 3'd5);
        end else if (w_isStore) begin
            w_func3Ok = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2);
        end
        case (func3[1:0])
            2'd1:    w_misaligned = alu_out[0];
            2'd2:    w_misaligned = (alu_out[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        w_decodeErr = (w_isLoad || w_isStore) && (!w_func3Ok || w_misaligned);
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        case (func3[1:0])
            2'd0: begin
                w_be    = 4'b0001 << alu_out[1:0];
                w_wdata = {4{rs2_data[7:0]}};
            end
            2'd1: begin
                w_be    = alu_out[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = rs2_data;
            end
        endcase
    end

    // Lane extraction uses the captured address against the live response word.
    always_comb begin
        w_loadData = 32'd0;
        case (r_addr[1:0])
            2'd0:    w_loadByte = mem_rdata[7:0];
            2'd1:    w_loadByte = mem_rdata[15:8];
            2'd2:    w_loadByte = mem_rdata[23:16];
            default: w_loadByte = mem_rdata[31:24];
        endcase
        w_loadHalf = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_func3)
            3'd0:    w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
            3'd1:    w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
            3'd2:    w_loadData = mem_rdata;
            3'd4:    w_loadData = {24'd0, w_loadByte};
            3'd5:    w_loadData = {16'd0, w_loadHalf};
            default: w_loadData = 32'd0;
        endcase
    end

    assign w_timeoutHit = (r_count == LAST_WAIT_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A response on the timeout cycle still counts as success.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (!(w_isLoad || w_isStore) || w_decodeErr) begin
                        w_next = DONE;
                    end else begin
                        w_next = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || w_timeoutHit) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_isStore <= 1'b0;
            r_func3   <= 3'd0;
            r_wbReg   <= 1'b0;
            r_rdNum   <= 5'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_result  <= 32'd0;
            r_err     <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_isStore <= w_isStore;
                        r_func3   <= func3;
                        r_wbReg   <= wb_reg;
                        r_rdNum   <= rd_num;
                        r_addr    <= alu_out;
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_result  <= alu_out;
                        r_err     <= w_decodeErr;
                        r_count   <= 8'd0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_result <= w_loadData;
                    end else begin
                        r_count <= r_count + 8'd1;
                        if (w_timeoutHit) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_wbEn = (r_state == DONE) && r_wbReg && !r_err && !r_isStore && (r_rdNum != 5'd0);

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_be     = 4'd0;
        mem_wdata  = 32'd0;
        done       = 1'b0;
        err        = 1'b0;
        wb_enable  = 1'b0;
        wb_rd_num  = 5'd0;
        wb_rd_data = 32'd0;
        case (r_state)
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_isStore;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_be    = r_be;
                mem_wdata = r_isStore ? r_wdata : 32'd0;
            end
            DONE: begin
                done      = 1'b1;
                err       = r_err;
                wb_enable = w_wbEn;
                if (w_wbEn) begin
                    wb_rd_num  = r_rdNum;
                    wb_rd_data = r_result;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access and write-back stage: consumes the decode/execute stage outputs (opcode, func3, wb_reg, rd_num, ALU result, rs2 data).
- Performs RV32I loads and stores on a req/gnt/rvalid data-memory bus and drives regfile write-back.
- Reports completion and errors to the controller, which stalls fetch until done.

Parameters:
TIMEOUT, 255, max cycles waited in WAIT for mem_rvalid before aborting with err (1..255)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse: operands valid, begin operation
opcode  input  7  instruction opcode
func3  input  3  access size/sign
wb_reg  input  1  instruction writes rd
rd_num  input  5  destination register
alu_out  input  32  effective address (load/store) or result (others)
rs2_data  input  32  store data
wb_enable  output  1  regfile write strobe
wb_rd_num  output  5  regfile write index
wb_rd_data  output  32  regfile write data
done  output  1  one-cycle completion pulse to controller
err  output  1  one-cycle pulse with done: misaligned, illegal func3, or timeout
mem_req  output  1  bus request
mem_we  output  1  1 = store
mem_addr  output  32  word-aligned address ({alu_out[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  32  lane-shifted store data
mem_gnt  input  1  request accepted
mem_rvalid  input  1  response/ack; mem_rdata valid for loads
mem_rdata  input  32  load data word

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; captured operands cleared. Reset mid-operation drops mem_req the next cycle with no done/wb. A late mem_rvalid arriving in IDLE is ignored.
- Capture: in IDLE, start latches all inputs. start outside IDLE is ignored.
- States:
  - IDLE: on start, decode the latched op:
    - opcode not 0000011 (LOAD) and not 0100011 (STORE) -> DONE.
    - Illegal func3 -> DONE with err. LOAD legal: 0,1,2,4,5. STORE legal: 0,1,2.
    - Misaligned -> DONE with err. Half: addr[0]=1. Word: addr[1:0]!=0.
    - Otherwise -> REQ.
  - REQ: mem_req=1, with mem_we/addr/be/wdata held stable. mem_gnt=1 -> WAIT (mem_req drops the following cycle). Waits in REQ indefinitely; no timeout.
  - WAIT: counter increments each cycle. mem_rvalid -> DONE. Counter reaches TIMEOUT -> DONE with err.
  - DONE: done=1 for exactly one cycle, err as flagged, then -> IDLE.
- Write-back (in DONE only):
  - wb_enable = wb_reg & !err & (rd_num!=0); stores never write back.
  - Non-memory op: wb_rd_data = alu_out.
  - Load:
    - Select byte lane by addr[1:0], half lane by addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - wb_rd_num = rd_num. When wb_enable=0, wb_rd_num and wb_rd_data are 0.
- Store lanes:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 or 1100 by addr[1]; wdata = half replicated x2.
  - SW: be = 1111.
- Latency, zero-wait memory (start at edge t, gnt at t+1, rvalid at t+2): mem_req high in cycle t+1, done at t+3. Non-memory op or error: done at t+1. Next start is accepted from the cycle after done.
- Simultaneous: mem_rvalid on the same cycle the counter hits TIMEOUT counts as success. mem_rvalid in REQ (before gnt) is ignored.

Test Plan:
- ADD result (opcode 0110011, wb_reg=1, rd=5, alu_out=0x1234) start -> done next cycle, wb_enable=1, wb_rd_num=5, wb_rd_data=0x1234, mem_req never high.
- LB addr 0x103, mem_rdata=0x80FF_FF7F -> mem_addr=0x100, done at t+3, wb_rd_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH addr 0x202, rs2=0xABCD_1234 -> mem_we=1, mem_be=1100, mem_wdata=0x1234_1234; done on ack with wb_enable=0.
- LW addr 0x101 -> no mem_req, done and err at t+1, wb_enable=0. SB with func3=3 -> same.
- LW with gnt delayed 3 cycles and rvalid never returned, TIMEOUT=4 -> mem_req held 3 cycles, done+err 4 cycles after entering WAIT, no write-back.
- LW rd=0, rvalid on time -> done, wb_enable=0. Assert rst while in WAIT -> mem_req/done 0 next cycle, late rvalid ignored, next start works normally.
